sram_responder: RTL and testbench
=================================

// Module: sram_responder
// PURPOSE
//  Synthesizable responder for the 16-bit asynchronous-style SRAM bus (IS61LV25616 pinout) that our
//  SRAM controller drives. Acts as the memory end of that bus in simulation and FPGA self-test builds.
//  Stores DEPTH x 16-bit words, honours byte lanes, and returns read data one clock (READ_LATENCY)
//  after the address, matching the controller's capture timing. Also counts accesses and flags
//  out-of-range addresses.
// PARAMETERS
//  ADDR_WIDTH    18    width of SRAM_ADDR
//  DEPTH         1024  words implemented; index = SRAM_ADDR mod DEPTH (DEPTH must be a power of 2)
//  READ_LATENCY  1     clocks from address capture to data on SRAM_DQ; legal 1..4
//  CNT_WIDTH     32    width of the access counters
// PORTS
//  clk        in     1           single clock; all state updates on posedge
//  rst        in     1           asynchronous, active-low reset (0 = reset)
//  SRAM_DQ    inout  16          data bus; driven only per read rules below, else 16'bz
//  SRAM_ADDR  in     ADDR_WIDTH  word address
//  SRAM_UB_N  in     1           upper byte lane enable [15:8], active-low
//  SRAM_LB_N  in     1           lower byte lane enable [7:0], active-low
//  SRAM_WE_N  in     1           write enable, active-low
//  SRAM_CE_N  in     1           chip enable, active-low
//  SRAM_OE_N  in     1           output enable, active-low
//  wr_count   out    CNT_WIDTH   number of write cycles accepted
//  rd_count   out    CNT_WIDTH   number of read cycles captured
//  addr_err   out    1           sticky: some access had SRAM_ADDR >= DEPTH
//  dbg_addr   in     ADDR_WIDTH  backdoor read address (bench use)
//  dbg_data   out    16          combinational mem[dbg_addr mod DEPTH]
// BEHAVIOUR
//  - Reset (rst=0): wr_count=0, rd_count=0, addr_err=0, all read-pipe valid bits=0, SRAM_DQ=z.
//    Memory contents are NOT cleared. Reset asserted mid-read kills in-flight data (DQ goes z
//    immediately); a write edge coinciding with reset is dropped.
//  - Write cycle: posedge with CE_N=0 and WE_N=0 -> mem[idx][15:8]<=DQ[15:8] if UB_N=0;
//    mem[idx][7:0]<=DQ[7:0] if LB_N=0; wr_count+=1 (even if both lanes disabled).
//  - Read capture: posedge with CE_N=0 and WE_N=1 -> stage1 <= {valid=1, data=mem[idx] (pre-edge
//    contents), ub=~UB_N, lb=~LB_N}; rd_count+=1. Other edges load stage1 valid=0.
//  - Pipe: stage k <= stage k-1 each posedge; output stage = stage READ_LATENCY.
//  - DQ drive: lane driven with output-stage data iff out.valid and CE_N=0 and OE_N=0 and WE_N=1
//    (current-cycle pins) and that lane's captured enable is set; otherwise lane is z. WE_N=0
//    always forces z (controller owns the bus) -> no contention in write cycles.
//  - Latency 1: address A at cycle n -> mem[A] on DQ during cycle n+1, so back-to-back reads of
//    A, A+1 stream one word per clock.
//  - Read-after-write: write A at cycle n, read A at cycle n+1 returns new data. A write landing
//    while a read of A is in flight does not alter that in-flight data.
//  - addr_err: set on any write/read-capture edge with SRAM_ADDR >= DEPTH; cleared only by reset.
//    Access still proceeds on the wrapped index.
//  - Counters wrap from all-ones to 0 with no flag.
//  - CE_N=1: no write, no capture, counters hold, DQ z.
// TESTING
//  1 Reset, then write 16'hBEEF @2 and 16'hDEAD @3 (UB/LB=0) -> dbg_data @2=BEEF, @3=DEAD, wr_count=2.
//  2 Read 2,3 back-to-back -> DQ=BEEF in cycle after addr 2, DEAD after addr 3; rd_count=2.
//  3 Write 16'h1234 @5 with UB_N=1 over prior 16'hFFFF -> mem[5]=FF34; read with LB_N=1 -> DQ=FFzz.
//  4 Read @3 with OE_N=1 in data cycle -> DQ=zzzz; same with WE_N=0 -> zzzz, no contention.
//  5 Access addr 1027 (DEPTH=1024) -> addr_err=1, hits index 3; stays 1 until rst=0.
//  6 READ_LATENCY=3: read @2, assert rst low 1 cycle later -> DQ z at once, counters 0, mem kept.

Source files
------------

// File: rtl/sram_if.sv
// sram_if: address and control pins of the 16-bit SRAM bus (data lines are a separate tristate net)
interface sram_if #(parameter int ADDR_WIDTH = 18);
  logic [ADDR_WIDTH-1:0] SRAM_ADDR;
  logic SRAM_UB_N;
  logic SRAM_LB_N;
  logic SRAM_WE_N;
  logic SRAM_CE_N;
  logic SRAM_OE_N;
  modport master(output SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N);
  modport slave(input SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N);
endinterface

// File: rtl/sram_responder.sv
// sram_responder: memory end of the 16-bit SRAM bus with byte lanes, pipelined reads, access counters and range flag
module sram_responder #(
  parameter int ADDR_WIDTH = 18,
  parameter int DEPTH = 1024,
  parameter int READ_LATENCY = 1,
  parameter int CNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_if.slave                 bus,
  inout  wire  [15:0]           SRAM_DQ,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  addr_err,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [15:0]           dbg_data
);
  localparam int IW = $clog2(DEPTH);
  typedef struct packed {
    logic        v;
    logic        ub;
    logic        lb;
    logic [15:0] d;
  } stage_t;
  logic [15:0] mem [DEPTH];
  stage_t [READ_LATENCY:1] pipe;
  stage_t out;
  logic [IW-1:0] idx;
  logic wr, rd, oob, go;
  assign idx = IW'(bus.SRAM_ADDR);
  assign wr = !bus.SRAM_CE_N && !bus.SRAM_WE_N;
  assign rd = !bus.SRAM_CE_N && bus.SRAM_WE_N;
  assign oob = (bus.SRAM_ADDR >> IW) != '0;
  assign out = pipe[READ_LATENCY];
  assign go = out.v && !bus.SRAM_CE_N && !bus.SRAM_OE_N && bus.SRAM_WE_N;
  assign SRAM_DQ[15:8] = (go && out.ub) ? out.d[15:8] : 8'bz;
  assign SRAM_DQ[7:0] = (go && out.lb) ? out.d[7:0] : 8'bz;
  assign dbg_data = mem[IW'(dbg_addr)];
  // Contents survive reset; rst gating only drops a write edge that coincides with reset.
  always_ff @(posedge clk) begin
    if (rst && wr) begin
      if (!bus.SRAM_UB_N) mem[idx][15:8] <= SRAM_DQ[15:8];
      if (!bus.SRAM_LB_N) mem[idx][7:0] <= SRAM_DQ[7:0];
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_count <= '0;
      rd_count <= '0;
      addr_err <= 1'b0;
      pipe <= '0;
    end else begin
      wr_count <= wr_count + CNT_WIDTH'(wr);
      rd_count <= rd_count + CNT_WIDTH'(rd);
      addr_err <= addr_err | ((wr | rd) & oob);
      pipe[1] <= rd ? {1'b1, ~bus.SRAM_UB_N, ~bus.SRAM_LB_N, mem[idx]} : '0;
      for (int i = 2; i <= READ_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed checks of the SRAM responder; undriven data lines are pulled low so z reads as 0
module tb_sram_responder;
  logic clk = 1'b0;
  logic rst0 = 1'b0;
  logic rst1 = 1'b0;
  always #5 clk = ~clk;
  sram_if #(.ADDR_WIDTH(18)) b0();
  sram_if #(.ADDR_WIDTH(18)) b1();
  wire [15:0] dq0, dq1;
  logic tb_en = 1'b0;
  logic [15:0] tb_d = '0;
  logic tb_en1 = 1'b0;
  logic [15:0] tb_d1 = '0;
  logic [17:0] dbg0 = '0, dbg1 = '0;
  logic [31:0] wr0, rd0, wr1, rd1;
  logic err0, err1;
  logic [15:0] dd0, dd1;
  int checks = 0;
  int fails = 0;
  assign dq0 = tb_en ? tb_d : 16'bz;
  assign dq1 = tb_en1 ? tb_d1 : 16'bz;
  for (genvar g = 0; g < 16; g++) begin : g_pd
    pulldown (dq0[g]);
    pulldown (dq1[g]);
  end
  sram_responder #(.READ_LATENCY(1)) u0 (
    .clk(clk), .rst(rst0), .bus(b0), .SRAM_DQ(dq0), .wr_count(wr0), .rd_count(rd0),
    .addr_err(err0), .dbg_addr(dbg0), .dbg_data(dd0));
  sram_responder #(.READ_LATENCY(3)) u1 (
    .clk(clk), .rst(rst1), .bus(b1), .SRAM_DQ(dq1), .wr_count(wr1), .rd_count(rd1),
    .addr_err(err1), .dbg_addr(dbg1), .dbg_data(dd1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic pins(input logic ce, we, oe, ub, lb, input logic [17:0] a);
    b0.SRAM_CE_N = ce;
    b0.SRAM_WE_N = we;
    b0.SRAM_OE_N = oe;
    b0.SRAM_UB_N = ub;
    b0.SRAM_LB_N = lb;
    b0.SRAM_ADDR = a;
  endtask

  task automatic wr_word(input logic [17:0] a, input logic [15:0] d, input logic ub, lb);
    pins(0, 0, 1, ub, lb, a);
    tb_en = 1'b1;
    tb_d = d;
    tick;
    tb_en = 1'b0;
    pins(1, 1, 1, 0, 0, a);
  endtask

  initial begin
    pins(1, 1, 1, 0, 0, 0);
    b1.SRAM_CE_N = 1; b1.SRAM_WE_N = 1; b1.SRAM_OE_N = 1;
    b1.SRAM_UB_N = 0; b1.SRAM_LB_N = 0; b1.SRAM_ADDR = 0;
    tick;
    tick;
    chk("rst_wr", wr0, 0);
    chk("rst_rd", rd0, 0);
    chk("rst_err", {31'd0, err0}, 0);
    chk("rst_dq", {16'd0, dq0}, 0);
    rst0 = 1'b1;
    rst1 = 1'b1;
    tick;
    // writes and backdoor readback
    wr_word(2, 16'hBEEF, 0, 0);
    wr_word(3, 16'hDEAD, 0, 0);
    dbg0 = 2; #1;
    chk("mem2", {16'd0, dd0}, 32'hBEEF);
    dbg0 = 3; #1;
    chk("mem3", {16'd0, dd0}, 32'hDEAD);
    chk("wr_cnt2", wr0, 2);
    // back-to-back reads stream one word per clock
    pins(0, 1, 0, 0, 0, 2);
    tick;
    pins(0, 1, 0, 0, 0, 3);
    #1;
    chk("rd_beef", {16'd0, dq0}, 32'hBEEF);
    tick;
    chk("rd_dead", {16'd0, dq0}, 32'hDEAD);
    chk("rd_cnt2", rd0, 2);
    pins(1, 1, 1, 0, 0, 0);
    #1;
    chk("idle_dq", {16'd0, dq0}, 0);
    // byte-lane write and lane-masked read
    wr_word(5, 16'hFFFF, 0, 0);
    wr_word(5, 16'h1234, 1, 0);
    dbg0 = 5; #1;
    chk("mem5", {16'd0, dd0}, 32'hFF34);
    pins(0, 1, 0, 0, 1, 5);
    tick;
    chk("rd_ffzz", {16'd0, dq0}, 32'hFF00);
    pins(1, 1, 1, 0, 0, 0);
    // OE_N high and WE_N low both keep the bus released
    pins(0, 1, 0, 0, 0, 3);
    tick;
    b0.SRAM_OE_N = 1; #1;
    chk("oe_off", {16'd0, dq0}, 0);
    pins(1, 1, 1, 0, 0, 0);
    tick;
    pins(0, 1, 0, 0, 0, 3);
    tick;
    b0.SRAM_WE_N = 0;
    tb_en = 1'b1;
    tb_d = 16'h5555;
    #1;
    chk("we_nocont", {16'd0, dq0}, 32'h5555);
    pins(1, 1, 1, 0, 0, 0);
    tb_en = 1'b0;
    chk("wr_cnt4", wr0, 4);
    chk("rd_cnt5", rd0, 5);
    // read-after-write
    wr_word(7, 16'h7777, 0, 0);
    pins(0, 1, 0, 0, 0, 7);
    tick;
    chk("raw", {16'd0, dq0}, 32'h7777);
    pins(1, 1, 1, 0, 0, 0);
    chk("err_pre", {31'd0, err0}, 0);
    // out of range wraps onto index 3
    pins(0, 1, 0, 0, 0, 1027);
    tick;
    chk("err_set", {31'd0, err0}, 1);
    chk("wrap_dq", {16'd0, dq0}, 32'hDEAD);
    pins(1, 1, 1, 0, 0, 0);
    tick;
    tick;
    chk("err_sticky", {31'd0, err0}, 1);
    rst0 = 1'b0; #1;
    chk("err_clr", {31'd0, err0}, 0);
    chk("rst_wr2", wr0, 0);
    dbg0 = 3; #1;
    chk("mem_kept", {16'd0, dd0}, 32'hDEAD);
    // latency 3 instance
    b1.SRAM_CE_N = 0; b1.SRAM_WE_N = 0; b1.SRAM_ADDR = 2;
    tb_en1 = 1'b1; tb_d1 = 16'hBEEF;
    tick;
    tb_en1 = 1'b0;
    b1.SRAM_WE_N = 1; b1.SRAM_OE_N = 0;
    tick;
    tick;
    chk("l3_early", {16'd0, dq1}, 0);
    tick;
    chk("l3_data", {16'd0, dq1}, 32'hBEEF);
    b1.SRAM_CE_N = 1;
    tick;
    tick;
    tick;
    b1.SRAM_CE_N = 0;
    tick;
    tick;
    rst1 = 1'b0; #1;
    chk("l3_kill", {16'd0, dq1}, 0);
    chk("l3_wr0", wr1, 0);
    chk("l3_rd0", rd1, 0);
    tick;
    chk("l3_dead", {16'd0, dq1}, 0);
    dbg1 = 2; #1;
    chk("l3_mem", {16'd0, dd1}, 32'hBEEF);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
